// File: rtl/hazard_sched_if.sv
// Pipeline hazard scheduler bundle: ID/EX hazard inputs, MUL/DIV handshake,
// and the pipeline-register stall/flush controls driven back to the core.
interface hazard_sched_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       rs1_id;
  logic [4:0]       rs2_id;
  logic [6:0]       opcode_id;
  logic [4:0]       rd_ex;
  logic             MemRead_ex;
  logic             branch_taken_ex;
  logic             md_req_ex;
  logic             md_done;
  logic             stall_if;
  logic             stall_id;
  logic             stall_ex;
  logic             flush_id;
  logic             flush_ex;
  logic             flush_mem;
  logic             md_start;
  logic             md_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output rs1_id, rs2_id, opcode_id, rd_ex, MemRead_ex, branch_taken_ex, md_req_ex, md_done,
    input  stall_if, stall_id, stall_ex, flush_id, flush_ex, flush_mem, md_start, md_err, stall_cnt
  );

  modport slave (
    input  rs1_id, rs2_id, opcode_id, rd_ex, MemRead_ex, branch_taken_ex, md_req_ex, md_done,
    output stall_if, stall_id, stall_ex, flush_id, flush_ex, flush_mem, md_start, md_err, stall_cnt
  );
endinterface

// File: rtl/hazard_sched.sv
// Hazard scheduler for the 5-stage RV32 core: load-use bubbles, redirect flushes
// and MUL/DIV occupancy of EX with a timeout escape.
module hazard_sched #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_sched_if.slave hs
);
  localparam int TW = $clog2(MD_TIMEOUT) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(MD_TIMEOUT - 1);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic {RUN, MD_WAIT} state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             err_q, err_set;
  logic [CNT_W-1:0] cnt_q;

  logic uses_rs1, uses_rs2, load_use;
  logic sif, sid, sex, fid, fex, fmem, mds;

  always_comb begin
    uses_rs2 = (hs.opcode_id == OP_R) || (hs.opcode_id == OP_S) || (hs.opcode_id == OP_B);
    uses_rs1 = !((hs.opcode_id == OP_LUI) || (hs.opcode_id == OP_AUIPC) || (hs.opcode_id == OP_JAL));
    load_use = hs.MemRead_ex && (hs.rd_ex != 5'd0) &&
               ((uses_rs1 && (hs.rd_ex == hs.rs1_id)) || (uses_rs2 && (hs.rd_ex == hs.rs2_id)));
  end

  always_comb begin
    sif = 1'b0; sid = 1'b0; sex = 1'b0;
    fid = 1'b0; fex = 1'b0; fmem = 1'b0; mds = 1'b0;
    state_d = state_q;
    tmo_d   = tmo_q;
    err_set = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        RUN: begin
          if (hs.branch_taken_ex) begin
            fid = 1'b1; fex = 1'b1;
          end else if (hs.md_req_ex) begin
            mds = 1'b1; sif = 1'b1; sid = 1'b1; sex = 1'b1; fmem = 1'b1;
            state_d = MD_WAIT;
            tmo_d   = TW'(1);
          end else if (load_use) begin
            sif = 1'b1; sid = 1'b1; fex = 1'b1;
          end
        end
        MD_WAIT: begin
          // md_req_ex is still high on the done cycle; returning to RUN without
          // a start pulse lets EX advance with the result.
          if (hs.md_done) begin
            state_d = RUN;
          end else if (tmo_q == TMO_LAST) begin
            err_set = 1'b1;
            state_d = RUN;
          end else begin
            sif = 1'b1; sid = 1'b1; sex = 1'b1; fmem = 1'b1;
            tmo_d = tmo_q + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      err_q   <= err_q | err_set;
      if (sif && (cnt_q != {CNT_W{1'b1}}))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign hs.stall_if  = sif;
  assign hs.stall_id  = sid;
  assign hs.stall_ex  = sex;
  assign hs.flush_id  = fid;
  assign hs.flush_ex  = fex;
  assign hs.flush_mem = fmem;
  assign hs.md_start  = mds;
  assign hs.md_err    = err_q;
  assign hs.stall_cnt = cnt_q;
endmodule
